// File: rtl/mem_stream_responder.sv
// Memory-side endpoint of the request/response stream link: turns header + data beats into
// single-word memory commands and returns read data in order. Optional checks: PROTOCOL_CHECK_EN.
module mem_stream_responder #(
  parameter int RESP_DEPTH = 4
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [127:0] req_axis_data,
  input  logic         req_axis_tuser,
  input  logic         req_axis_valid,
  output logic         req_axis_ready,
  output logic [127:0] resp_axis_data,
  output logic         resp_axis_tuser,
  output logic         resp_axis_valid,
  input  logic         resp_axis_ready,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic [26:0]  mem_addr,
  output logic         mem_wen,
  output logic [127:0] mem_wdata,
  input  logic         mem_rvalid,
  input  logic [127:0] mem_rdata,
  output logic         err_out
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e          state_q, state_d;
  logic [26:0]     addr_q, addr_d, len_q, len_d, cnt_q, cnt_d;
  logic            live_q;
  logic [CW-1:0]   occ_q, occ_d, outst_q, outst_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [127:0]    fifo_q [RESP_DEPTH];

  logic            hdr_take, wr_fire, rd_issue, push, pop, credit_ok, hdr_in_write;
  logic [CW-1:0]   used;

`ifdef PROTOCOL_CHECK_EN
  logic            err_q, err_d;
  assign hdr_in_write = req_axis_tuser;
  assign err_out      = err_q;
`else
  assign hdr_in_write = 1'b0;
  assign err_out      = 1'b0;
`endif

  // Credits cover both buffered and in-flight reads so a return always finds FIFO space.
  assign used      = occ_q + outst_q;
  assign credit_ok = used < CW'(RESP_DEPTH);
  assign push      = mem_rvalid && (outst_q != '0);
  assign pop       = resp_axis_valid && resp_axis_ready;
  assign rd_issue  = (state_q == READ) && mem_valid && mem_ready;

  assign resp_axis_valid = (occ_q != '0);
  assign resp_axis_data  = resp_axis_valid ? fifo_q[rd_ptr_q] : '0;
  assign resp_axis_tuser = 1'b0;

  always_comb begin
    req_axis_ready = 1'b0;
    mem_valid      = 1'b0;
    mem_wen        = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (state_q)
      IDLE:  req_axis_ready = live_q;
      WRITE: begin
        req_axis_ready = hdr_in_write | mem_ready;
        mem_valid      = req_axis_valid & ~hdr_in_write;
        mem_wen        = 1'b1;
        mem_addr       = addr_q + cnt_q;
        mem_wdata      = req_axis_data;
      end
      READ: begin
        mem_valid = credit_ok;
        mem_addr  = addr_q + cnt_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hdr_take = 1'b0;
    wr_fire  = 1'b0;
`ifdef PROTOCOL_CHECK_EN
    err_d    = err_q;
    if (mem_rvalid && (outst_q == '0)) err_d = 1'b1;
`endif
    case (state_q)
      IDLE: if (req_axis_valid && req_axis_ready) begin
        hdr_take = req_axis_tuser;
`ifdef PROTOCOL_CHECK_EN
        if (!req_axis_tuser) err_d = 1'b1;
`endif
      end
      WRITE: if (req_axis_valid && req_axis_ready) begin
        hdr_take = hdr_in_write;
        wr_fire  = ~hdr_in_write;
`ifdef PROTOCOL_CHECK_EN
        if (hdr_in_write) err_d = 1'b1;
`endif
      end
      READ: if (rd_issue) begin
        cnt_d = cnt_q + 27'd1;
        if (cnt_q == len_q - 27'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wr_fire) begin
      cnt_d = cnt_q + 27'd1;
      if (cnt_q == len_q - 27'd1) state_d = IDLE;
    end
    // A new header always wins, including one that abandons a write burst.
    if (hdr_take) begin
      addr_d = req_axis_data[54:28];
      len_d  = req_axis_data[27:1];
      cnt_d  = '0;
      if (req_axis_data[27:1] == 27'd0) state_d = IDLE;
      else if (req_axis_data[0])        state_d = WRITE;
      else                              state_d = READ;
    end
  end

  assign occ_d   = occ_q + CW'(push) - CW'(pop);
  assign outst_d = outst_q + CW'(rd_issue) - CW'(push);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      live_q   <= 1'b0;
      occ_q    <= '0;
      outst_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef PROTOCOL_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      live_q   <= 1'b1;
      occ_q    <= occ_d;
      outst_q  <= outst_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
`ifdef PROTOCOL_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_q[wr_ptr_q] <= mem_rdata;
  end

endmodule

// File: doc/mem_stream_responder.md
# mem_stream_responder

Memory-side endpoint of the 128-bit request/response AXI-Stream link. Accepts the request stream: one `tuser` header beat carrying a `channel_update`, then, for writes, `stream_length` data beats. Turns each beat into a single-word command on a 128-bit memory port and returns read data in order on the response stream. Sits between the stream link and the memory controller, opposite the processor-side request serializer and response accumulator.

## Interface
- `RESP_DEPTH`, 4 — response FIFO entries; also the cap on outstanding plus buffered reads (power of 2, ≥2).
- `clk_in` in 1 — single clock.
- `rst_n_in` in 1 — asynchronous, active-low reset.
- `req_axis_data` in 128 — request beat; header = zero-extended `channel_update`: `wen` [0], `stream_length` [27:1], `addr` [54:28].
- `req_axis_tuser` in 1 — 1 marks a header beat.
- `req_axis_valid` in 1, `req_axis_ready` out 1 — request handshake.
- `resp_axis_data` out 128, `resp_axis_tuser` out 1 (tied 0), `resp_axis_valid` out 1, `resp_axis_ready` in 1 — response stream.
- `mem_valid` out 1, `mem_ready` in 1 — memory command handshake.
- `mem_addr` out 27 — 128-bit word address.
- `mem_wen` out 1 — 1 = write command.
- `mem_wdata` out 128 — write data.
- `mem_rvalid` in 1, `mem_rdata` in 128 — in-order read return; no backpressure.
- `err_out` out 1 — sticky protocol-error flag.

## Operation
- States: IDLE, WRITE, READ.
- IDLE: `req_axis_ready`=1.
  - Header beat accepted → latch `addr`, `stream_length`, `wen`; clear beat counter.
  - `stream_length`=0 → stay in IDLE; no memory traffic.
  - Otherwise `wen`=1 → WRITE; `wen`=0 → READ.
  - Non-header beat in IDLE → consumed and dropped.
- WRITE: `mem_valid`=`req_axis_valid`; `req_axis_ready`=`mem_ready`; `mem_wen`=1; `mem_addr`=`addr`+count; `mem_wdata`=`req_axis_data`.
  - Each accepted beat increments count.
  - Beat with count = `stream_length`-1 → IDLE.
- READ: `req_axis_ready`=0; `mem_valid`=1 while credits>0; `mem_wen`=0; `mem_addr`=`addr`+count.
  - Each `mem_valid && mem_ready` increments count and the outstanding counter.
  - After the last issue → IDLE. Data still returning does not block the next header.
- Credits = `RESP_DEPTH` − (FIFO occupancy + outstanding).
- `mem_rvalid` pushes `mem_rdata` into the FIFO and decrements outstanding. Credits guarantee the FIFO has space.
- A push and a pop in the same cycle leave occupancy unchanged.
- Address arithmetic is 27-bit modulo: `addr`+count wraps from 0x7FFFFFF to 0.
- `mem_rvalid` while outstanding=0 → dropped, no state change.

## Timing
- Reset values: `req_axis_ready`=0, `resp_axis_valid`=0, `resp_axis_data`=0, `mem_valid`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0, `err_out`=0. State=IDLE; FIFO and counters cleared.
- `req_axis_ready` rises the first cycle after reset deassertion.
- Reset mid-transfer aborts the burst. Buffered and outstanding reads are discarded.
- Header accepted at cycle N → first `mem_valid` at N+1.
- WRITE is combinational pass-through, zero added latency: one beat per cycle at full throughput.
- `mem_rvalid` at cycle M → `resp_axis_valid` at M+1 (registered FIFO output).
- Back-to-back pops sustain one beat per cycle.
- Once asserted, `resp_axis_valid` and `resp_axis_data` hold until accepted.
- Read issue rate is one per cycle while credits>0. With `resp_axis_ready` held low, at most `RESP_DEPTH` reads are issued and then `mem_valid` drops.
- Back-to-back headers: the next header may be accepted in the cycle after the last beat/issue of the previous burst.

## Configuration
- `PROTOCOL_CHECK_EN` defined:
  - Header beat in WRITE is accepted as a new header; the current write burst is abandoned; `err_out` set.
  - Non-header beat in IDLE sets `err_out`.
  - `mem_rvalid` while outstanding=0 sets `err_out`.
  - `err_out` clears only on reset.
- `PROTOCOL_CHECK_EN` not defined:
  - `err_out` tied 0.
  - `tuser` in WRITE is ignored; the beat is treated as data.

## Test plan
- Write header addr=0x40, len=4, wen=1, then data D0..D3 with `mem_ready`=1 → four commands, addr 0x40..0x43, wen=1, wdata D0..D3; IDLE after D3.
- Read header addr=0x100, len=4; memory returns R0..R3 two cycles after each issue; `resp_axis_ready`=1 → `resp_axis` emits R0..R3 in order, each one cycle after its `mem_rvalid`.
- Read len=8 with `resp_axis_ready`=0 → exactly 4 (=`RESP_DEPTH`) issues, then `mem_valid`=0. Raise ready → remaining 4 issue; all 8 beats arrive in order.
- Header addr=0x7FFFFFE, len=4, wen=0 → mem_addr sequence 0x7FFFFFE, 0x7FFFFFF, 0x0, 0x1.
- Header len=0 → no `mem_valid`; the next header is accepted the following cycle.
- `PROTOCOL_CHECK_EN`: header beat after 2 of 4 write data beats → `err_out`=1 and the new header is honored. Deassert `rst_n_in` mid-read → all outputs return to reset values immediately.
